// File: rtl/truth_table_sweeper.sv
// Walks the 8 input rows of a 3-input truth-table gate, samples its response per row
// and publishes the assembled hex code, per-row stability flags and a match verdict.
module truth_table_sweeper #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned SAMPLES       = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] expected_code,
    input  logic       probe_out,
    output logic       probe_in1,
    output logic       probe_in2,
    output logic       probe_in3,
    output logic       busy,
    output logic       done,
    output logic [7:0] code,
    output logic [7:0] unstable,
    output logic       match
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        PUBLISH
    } state_t;

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [3:0] SAMPLE_LAST = 4'(SAMPLES - 1);

    state_t     state_q;
    logic [2:0] row_q;
    logic [7:0] settle_cnt_q;
    logic [3:0] samp_cnt_q;
    logic [7:0] exp_q;
    logic [7:0] shadow_code_q;
    logic [7:0] shadow_unst_q;
    logic       ref_q;
    logic [2:0] probe_q;
    logic       busy_q;
    logic       done_q;
    logic [7:0] code_q;
    logic [7:0] unst_q;
    logic       match_q;

    // Row k lands in code bit 7-k, which for a 3-bit index is simply ~k.
    logic [2:0] code_idx;
    assign code_idx = ~row_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            row_q         <= 3'd0;
            settle_cnt_q  <= 8'd0;
            samp_cnt_q    <= 4'd0;
            exp_q         <= 8'd0;
            shadow_code_q <= 8'd0;
            shadow_unst_q <= 8'd0;
            ref_q         <= 1'b0;
            probe_q       <= 3'd0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            code_q        <= 8'd0;
            unst_q        <= 8'd0;
            match_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        exp_q         <= expected_code;
                        shadow_code_q <= 8'd0;
                        shadow_unst_q <= 8'd0;
                        row_q         <= 3'd0;
                        settle_cnt_q  <= 8'd0;
                        samp_cnt_q    <= 4'd0;
                        probe_q       <= 3'd0;
                        busy_q        <= 1'b1;
                        state_q       <= SETTLE;
                    end
                end

                SETTLE: begin
                    if (settle_cnt_q == SETTLE_LAST) begin
                        settle_cnt_q <= 8'd0;
                        samp_cnt_q   <= 4'd0;
                        state_q      <= SAMPLE;
                    end else begin
                        settle_cnt_q <= settle_cnt_q + 8'd1;
                    end
                end

                SAMPLE: begin
                    // The first sample of a row is the reference the later ones must agree with.
                    if (samp_cnt_q == 4'd0) begin
                        ref_q <= probe_out;
                    end else if (probe_out != ref_q) begin
                        shadow_unst_q[code_idx] <= 1'b1;
                    end

                    if (samp_cnt_q == SAMPLE_LAST) begin
                        shadow_code_q[code_idx] <= probe_out;
                        samp_cnt_q              <= 4'd0;
                        if (row_q == 3'd7) begin
                            probe_q <= 3'd0;
                            busy_q  <= 1'b0;
                            state_q <= PUBLISH;
                        end else begin
                            row_q   <= row_q + 3'd1;
                            probe_q <= row_q + 3'd1;
                            state_q <= SETTLE;
                        end
                    end else begin
                        samp_cnt_q <= samp_cnt_q + 4'd1;
                    end
                end

                PUBLISH: begin
                    code_q  <= shadow_code_q;
                    unst_q  <= shadow_unst_q;
                    match_q <= (shadow_code_q == exp_q) && (shadow_unst_q == 8'd0);
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign probe_in1 = probe_q[2];
    assign probe_in2 = probe_q[1];
    assign probe_in3 = probe_q[0];
    assign busy      = busy_q;
    assign done      = done_q;
    assign code      = code_q;
    assign unstable  = unst_q;
    assign match     = match_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench: sweeps push expected results, done-driven monitors pop and compare.
module tb_truth_table_sweeper;

    typedef struct packed {
        logic [7:0] code;
        logic [7:0] unst;
        logic       m;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int nchk  = 0;
    int npass = 0;

    // Instance A: SETTLE=4, SAMPLES=2, combinational gate
    logic       start_a = 1'b0;
    logic [7:0] exp_a   = 8'h00;
    logic [7:0] tt_a    = 8'h8D;
    logic       pout_a, p1_a, p2_a, p3_a, busy_a, done_a, match_a;
    logic [7:0] code_a, unst_a;
    logic [2:0] row_a;
    assign row_a  = {p1_a, p2_a, p3_a};
    assign pout_a = tt_a[~row_a];

    truth_table_sweeper #(.SETTLE_CYCLES(4), .SAMPLES(2)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .expected_code(exp_a),
        .probe_out(pout_a), .probe_in1(p1_a), .probe_in2(p2_a), .probe_in3(p3_a),
        .busy(busy_a), .done(done_a), .code(code_a), .unstable(unst_a), .match(match_a)
    );

    // Instance B: SETTLE=1, SAMPLES=3, gate output delayed by two clocks
    logic       start_b = 1'b0;
    logic [7:0] exp_b   = 8'h00;
    logic [7:0] tt_b    = 8'h8D;
    logic       d1_b = 1'b0, d2_b = 1'b0;
    logic       p1_b, p2_b, p3_b, busy_b, done_b, match_b;
    logic [7:0] code_b, unst_b;
    logic [2:0] row_b;
    assign row_b = {p1_b, p2_b, p3_b};
    always @(posedge clk) begin
        d1_b <= tt_b[~row_b];
        d2_b <= d1_b;
    end

    truth_table_sweeper #(.SETTLE_CYCLES(1), .SAMPLES(3)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .expected_code(exp_b),
        .probe_out(d2_b), .probe_in1(p1_b), .probe_in2(p2_b), .probe_in3(p3_b),
        .busy(busy_b), .done(done_b), .code(code_b), .unstable(unst_b), .match(match_b)
    );

    res_t q_a[$];
    res_t q_b[$];

    function automatic res_t mk(input logic [7:0] c, input logic [7:0] u, input logic m);
        res_t r;
        r.code = c;
        r.unst = u;
        r.m    = m;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        nchk++;
        if (act === req) npass++;
        else $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    endtask

    // Monitors: compare published results whenever done pulses
    always @(negedge clk) begin
        if (done_a) begin
            if (q_a.size() == 0) begin
                nchk++;
                $display("FAIL a_unexpected_done: got done=1, required no done (t=%0t)", $time);
            end else begin
                res_t r;
                r = q_a.pop_front();
                check("a_code", code_a, r.code);
                check("a_unstable", unst_a, r.unst);
                check("a_match", match_a, r.m);
            end
        end
    end

    always @(negedge clk) begin
        if (done_b) begin
            if (q_b.size() == 0) begin
                nchk++;
                $display("FAIL b_unexpected_done: got done=1, required no done (t=%0t)", $time);
            end else begin
                res_t r;
                r = q_b.pop_front();
                check("b_code", code_b, r.code);
                check("b_unstable", unst_b, r.unst);
                check("b_match", match_b, r.m);
            end
        end
    end

    // One full sweep on instance A; returns at the negedge one cycle after done
    task automatic sweep_a(input logic [7:0] ex, input res_t want, input bit extra_starts,
                           input logic [7:0] hold_code);
        int n;
        int bad;
        exp_a   = ex;
        start_a = 1'b1;
        q_a.push_back(want);
        @(negedge clk);
        start_a = 1'b0;
        exp_a   = ~ex;
        n   = 0;
        bad = 0;
        while (busy_a && n < 1000) begin
            if (row_a != 3'(n / 6)) bad++;
            if (n == 24) check("a_code_hold", code_a, hold_code);
            start_a = (extra_starts && (n == 5 || n == 30)) ? 1'b1 : 1'b0;
            n++;
            @(negedge clk);
        end
        start_a = 1'b0;
        check("a_busy_len", n, 48);
        check("a_probe_seq", bad, 0);
        check("a_done_lag", done_a, 1'b0);
        @(negedge clk);
        check("a_done_pulse", done_a, 1'b1);
        check("a_probe_idle", row_a, 3'd0);
        @(negedge clk);
        check("a_done_single", done_a, 1'b0);
    endtask

    initial begin
        int n;
        int k;
        #12;
        check("rst_busy", busy_a, 1'b0);
        check("rst_done", done_a, 1'b0);
        check("rst_code", code_a, 8'h00);
        check("rst_match", match_a, 1'b0);
        check("rst_probes", row_a, 3'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Mismatching expected code, then matching one
        tt_a = 8'h8D;
        sweep_a(8'h8C, mk(8'h8D, 8'h00, 1'b0), 1'b0, 8'h00);
        sweep_a(8'h8D, mk(8'h8D, 8'h00, 1'b1), 1'b0, 8'h8D);

        // Asynchronous abort partway through a sweep
        exp_a   = 8'h8D;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (19) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", busy_a, 1'b0);
        check("abort_done", done_a, 1'b0);
        check("abort_probes", row_a, 3'd0);
        check("abort_code", code_a, 8'h00);
        check("abort_match", match_a, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        sweep_a(8'h8D, mk(8'h8D, 8'h00, 1'b1), 1'b0, 8'h00);

        // Ignored starts mid-sweep, then back-to-back sweep holding prior result
        sweep_a(8'h8D, mk(8'h8D, 8'h00, 1'b1), 1'b1, 8'h8D);
        tt_a = 8'h3C;
        sweep_a(8'h3C, mk(8'h3C, 8'h00, 1'b1), 1'b0, 8'h8D);

        // Constant gates
        tt_a = 8'hFF;
        sweep_a(8'hFF, mk(8'hFF, 8'h00, 1'b1), 1'b0, 8'h3C);
        tt_a = 8'h00;
        sweep_a(8'h00, mk(8'h00, 8'h00, 1'b1), 1'b0, 8'hFF);
        sweep_a(8'hFF, mk(8'h00, 8'h00, 1'b0), 1'b0, 8'h00);

        // Delayed gate: reference sample sees the previous row's value
        exp_b   = 8'h8D;
        start_b = 1'b1;
        q_b.push_back(mk(8'h8D, 8'h4B, 1'b0));
        @(negedge clk);
        start_b = 1'b0;
        n = 0;
        while (busy_b && n < 1000) begin
            n++;
            @(negedge clk);
        end
        check("b_busy_len", n, 32);
        k = 0;
        while (!done_b && k < 5) begin
            k++;
            @(negedge clk);
        end
        check("b_done_seen", done_b, 1'b1);

        repeat (5) @(negedge clk);
        check("a_queue_drained", q_a.size(), 0);
        check("b_queue_drained", q_b.size(), 0);
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Reads back a 3-input, 1-output truth-table gate (the "0xNN" logic blocks) by walking all 8 input rows and capturing the response.
- Drives probe_in1..3, waits for the output to settle, samples probe_out, and assembles the 8-bit hex code of the gate.
- Compares the assembled code against an expected code.
- Used in gate-characterisation benches and self-test wrappers around synthesized truth-table logic.

Parameters:
- SETTLE_CYCLES, 4: cycles a row is held before sampling starts; legal range 1..255.
- SAMPLES, 2: consecutive samples taken per row; legal range 1..15.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begins a sweep when the FSM is IDLE.
- expected_code  input  8  reference code; sampled on the start cycle.
- probe_out  input  1  response of the gate under test.
- probe_in1  output  1  gate input 1 (MSB of the row index).
- probe_in2  output  1  gate input 2.
- probe_in3  output  1  gate input 3 (LSB of the row index).
- busy  output  1  high while a sweep is in progress.
- done  output  1  one-cycle pulse when results are published.
- code  output  8  captured truth table.
- unstable  output  8  per-row flag; set when the SAMPLES values for that row disagree.
- match  output  1  high when code == expected and unstable == 0.

Behaviour:
- Reset (asynchronous, active-high): state IDLE; all outputs 0; internal row, counters, shadow registers and latched expected code cleared.
- Code bit order: row k = {in1,in2,in3} maps to code[7-k]. Example: row 000 is code[7], row 111 is code[0], so rows 1,0,0,0,1,1,0,1 give 8'h8D.
- FSM states: IDLE, SETTLE, SAMPLE, PUBLISH.
- IDLE
  - Probes held at 000; busy=0.
  - start=1: latch expected_code, clear shadow code and shadow unstable, row=0, go to SETTLE.
- SETTLE
  - Probes = row; busy=1.
  - Counts SETTLE_CYCLES cycles, then goes to SAMPLE.
- SAMPLE
  - Probes = row.
  - Samples probe_out on each of SAMPLES cycles. The first sample is the row reference.
  - Any later sample that differs from the first sets shadow unstable[7-row].
  - The final sample is written to shadow code[7-row].
  - If row<7: row+1, go to SETTLE.
  - If row==7: go to PUBLISH.
- PUBLISH (one cycle)
  - Copies shadow registers to code and unstable.
  - match = (shadow code == latched expected) && (shadow unstable == 0).
  - done=1 for this cycle only; busy=0; probes return to 000; next state IDLE.
- Latency: each row takes SETTLE_CYCLES+SAMPLES cycles. busy is high for exactly 8*(SETTLE_CYCLES+SAMPLES) cycles; done follows one cycle after busy drops.
- Output hold: code, unstable and match keep the previous sweep's result throughout a sweep. They change only in PUBLISH.
- start while busy or in PUBLISH: ignored, no queueing. start in the cycle after done is accepted.
- Probe switching: probes change only on the SETTLE entry edge. No sample is taken in the cycle in which the probes change.
- expected_code changes mid-sweep: no effect; the latched value is used.
- Reset mid-sweep: immediate abort. Outputs clear to 0, including previously published results; no done pulse.
- Counters saturate-free: widths sized from the parameter maxima, 8 bits for settle and 4 bits for samples.

Test Plan:
1. Gate model 0x8D (combinational from probes), expected=8'h8D, SETTLE=4, SAMPLES=2, pulse start → busy high 48 cycles, then done pulse; code=8'h8D, unstable=0, match=1. Probes step 000..111, each held 6 cycles.
2. Same gate, expected=8'h8C → code=8'h8D, match=0.
3. Gate model with 2-cycle output delay, SETTLE=1, SAMPLES=3 → unstable nonzero on rows where the output toggles (e.g. row 001 after row 000 on 0x8D); match=0.
4. Assert rst asynchronously at cycle 20 of a sweep → busy, done, probes, code and match are 0 immediately; later start produces a clean full sweep.
5. Pulse start again at cycles 5 and 30 of a sweep → ignored, sweep length unchanged. Start in the cycle after done → second sweep begins; code holds the first result until the second PUBLISH.
6. Constant-1 gate then constant-0 gate → code=8'hFF, then 8'h00; match follows expected 8'hFF / 8'h00.
